// File: rtl/ua_switch_sequencer.sv
// rtl/ua_switch_sequencer.sv - break-before-make sequencer for the ua[] analog pin switch matrix
module ua_switch_sequencer #(
    parameter int NCH  = 6,
    parameter int DW   = 8,
    parameter int DEAD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           auto,
    input  logic [2:0]     ch_sel,
    input  logic [DW-1:0]  dwell,
    output logic [NCH-1:0] sw_en,
    output logic [2:0]     ch_cur,
    output logic           busy,
    output logic           sample,
    output logic           done,
    output logic           err
);

    // One counter serves both the dead time and the dwell, so it must fit either range.
    localparam int DEADW = $clog2(DEAD + 1);
    localparam int CW    = (DW > DEADW) ? DW : DEADW;

    localparam logic [CW-1:0]  LP_DEAD_M1 = CW'(DEAD - 1);
    localparam logic [3:0]     LP_NCH     = 4'(NCH);
    localparam logic [3:0]     LP_NCH_M1  = 4'(NCH - 1);
    localparam logic [NCH-1:0] LP_ONE     = {{(NCH-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]  LP_DW_ONE  = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_ch;
    logic            r_auto;
    logic [DW-1:0]   r_dwell;
    logic [NCH-1:0]  r_sw_en;
    logic            r_busy;
    logic            r_sample;
    logic            r_done;
    logic            r_err;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      w_ch_nxt;
    logic            w_auto_nxt;
    logic [DW-1:0]   w_dwell_nxt;
    logic [CW-1:0]   w_dwell_m1;
    logic [NCH-1:0]  w_sw_en_nxt;
    logic            w_busy_nxt;
    logic            w_sample_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;

    // Next-state logic; every output is computed one cycle ahead and registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ch_nxt     = r_ch;
        w_auto_nxt   = r_auto;
        w_dwell_nxt  = r_dwell;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        // Latched dwell is never 0, so this never underflows.
        w_dwell_m1   = CW'(r_dwell) - CW'(1);

        case (r_state)
            S_IDLE: begin
                // stop has priority over start, including over the reject check.
                if (start && !stop) begin
                    if (!auto && ({1'b0, ch_sel} >= LP_NCH)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_BREAK;
                        w_cnt_nxt   = '0;
                        w_auto_nxt  = auto;
                        w_dwell_nxt = (dwell == '0) ? LP_DW_ONE : dwell;
                        w_ch_nxt    = auto ? 3'd0 : ch_sel;
                    end
                end
            end
            S_BREAK: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == LP_DEAD_M1) begin
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_ON: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == w_dwell_m1) begin
                    if (r_auto && ({1'b0, r_ch} < LP_NCH_M1)) begin
                        w_state_nxt = S_BREAK;
                        w_cnt_nxt   = '0;
                        w_ch_nxt    = r_ch + 3'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Switch is closed only in ON; BREAK always separates two ON periods.
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_sw_en_nxt  = (w_state_nxt == S_ON) ? (LP_ONE << w_ch_nxt) : '0;
        w_sample_nxt = (w_state_nxt == S_ON) && (w_cnt_nxt == w_dwell_m1);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ch     <= 3'd0;
            r_auto   <= 1'b0;
            r_dwell  <= LP_DW_ONE;
            r_sw_en  <= '0;
            r_busy   <= 1'b0;
            r_sample <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ch     <= w_ch_nxt;
            r_auto   <= w_auto_nxt;
            r_dwell  <= w_dwell_nxt;
            r_sw_en  <= w_sw_en_nxt;
            r_busy   <= w_busy_nxt;
            r_sample <= w_sample_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign sw_en  = r_sw_en;
    assign ch_cur = r_ch;
    assign busy   = r_busy;
    assign sample = r_sample;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_ua_switch_sequencer.sv
// tb/tb_ua_switch_sequencer.sv - self-checking bench for ua_switch_sequencer
module tb_ua_switch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       au = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] dw = 8'd0;
    logic [5:0] sw_en;
    logic [2:0] ch_cur;
    logic       busy, sample, done, err;

    int n_checks = 0;
    int n_errors = 0;

    ua_switch_sequencer #(.NCH(6), .DW(8), .DEAD(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .auto(au),
        .ch_sel(sel), .dwell(dw), .sw_en(sw_en), .ch_cur(ch_cur),
        .busy(busy), .sample(sample), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, au;
        logic [2:0] sel;
        logic [7:0] dw;
        logic [5:0] e_sw;
        logic       e_busy, e_samp, e_done, e_err;
        logic [2:0] e_ch;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic p, input logic a, input logic [2:0] c,
                       input logic [7:0] d, input logic [5:0] esw, input logic eb,
                       input logic es, input logic ed, input logic ee, input logic [2:0] ech);
        vec_t v;
        v.start = s; v.stop = p; v.au = a; v.sel = c; v.dw = d;
        v.e_sw = esw; v.e_busy = eb; v.e_samp = es; v.e_done = ed; v.e_err = ee; v.e_ch = ech;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %0h want %0h", nm, k, act, want);
        end
    endtask

    task automatic chk_all(input string nm, input int k, input logic [5:0] esw, input logic eb,
                           input logic es, input logic ed, input logic ee, input logic [2:0] ech);
        chk({nm, ".sw_en"},  k, 32'(sw_en),  32'(esw));
        chk({nm, ".busy"},   k, 32'(busy),   32'(eb));
        chk({nm, ".sample"}, k, 32'(sample), 32'(es));
        chk({nm, ".done"},   k, 32'(done),   32'(ed));
        chk({nm, ".err"},    k, 32'(err),    32'(ee));
        chk({nm, ".ch_cur"}, k, 32'(ch_cur), 32'(ech));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Present a start in the current cycle; returns positioned in cycle 1.
    task automatic go(input logic a, input logic [2:0] c, input logic [7:0] d);
        au = a; sel = c; dw = d; start = 1'b1; stop = 1'b0;
        @(negedge clk);
        adv();
        start = 1'b0;
    endtask

    initial begin
        logic [5:0] esw;
        int pos, idx;

        // Single channel, reject, start+stop, stop in idle, dwell=0
        add(1,0,0,2,3, 6'h00,0,0,0,0,3'd0);
        add(0,0,0,2,3, 6'h00,1,0,0,0,3'd2);
        add(0,0,0,2,3, 6'h00,1,0,0,0,3'd2);
        add(0,0,0,2,3, 6'h00,1,0,0,0,3'd2);
        add(0,0,0,2,3, 6'h00,1,0,0,0,3'd2);
        add(0,0,0,2,3, 6'h04,1,0,0,0,3'd2);
        add(0,0,0,2,3, 6'h04,1,0,0,0,3'd2);
        add(0,0,0,2,3, 6'h04,1,1,0,0,3'd2);
        add(0,0,0,2,3, 6'h00,0,0,1,0,3'd2);
        add(1,0,0,7,3, 6'h00,0,0,0,0,3'd2);
        add(1,1,0,2,3, 6'h00,0,0,0,1,3'd2);
        add(1,1,0,7,3, 6'h00,0,0,0,0,3'd2);
        add(1,0,0,5,0, 6'h00,0,0,0,0,3'd2);
        add(0,0,0,5,0, 6'h00,1,0,0,0,3'd5);
        add(0,0,0,5,0, 6'h00,1,0,0,0,3'd5);
        add(0,0,0,5,0, 6'h00,1,0,0,0,3'd5);
        add(0,0,0,5,0, 6'h00,1,0,0,0,3'd5);
        add(0,0,0,5,0, 6'h20,1,1,0,0,3'd5);
        add(0,0,0,5,0, 6'h00,0,0,1,0,3'd5);
        add(0,1,0,5,0, 6'h00,0,0,0,0,3'd5);
        // start while busy is ignored; back-to-back start on the done cycle
        add(1,0,0,1,2, 6'h00,0,0,0,0,3'd5);
        add(0,0,0,1,2, 6'h00,1,0,0,0,3'd1);
        add(0,0,0,1,2, 6'h00,1,0,0,0,3'd1);
        add(1,0,1,4,9, 6'h00,1,0,0,0,3'd1);
        add(0,0,1,4,9, 6'h00,1,0,0,0,3'd1);
        add(0,0,1,4,9, 6'h02,1,0,0,0,3'd1);
        add(0,0,1,4,9, 6'h02,1,1,0,0,3'd1);
        add(1,0,0,3,1, 6'h00,0,0,1,0,3'd1);
        add(0,0,0,3,1, 6'h00,1,0,0,0,3'd3);
        add(0,0,0,3,1, 6'h00,1,0,0,0,3'd3);
        add(0,0,0,3,1, 6'h00,1,0,0,0,3'd3);
        add(0,0,0,3,1, 6'h00,1,0,0,0,3'd3);
        add(0,0,0,3,1, 6'h08,1,1,0,0,3'd3);
        add(0,0,0,3,1, 6'h00,0,0,1,0,3'd3);
        add(0,0,0,3,1, 6'h00,0,0,0,0,3'd3);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all("reset", 0, 6'h00, 0, 0, 0, 0, 3'd0);
        adv();

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; au = vecs[i].au;
            sel = vecs[i].sel; dw = vecs[i].dw;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), i, vecs[i].e_sw, vecs[i].e_busy,
                    vecs[i].e_samp, vecs[i].e_done, vecs[i].e_err, vecs[i].e_ch);
            adv();
        end
        start = 1'b0; stop = 1'b0;

        // Auto scan: 6 channels of 4 dead + 3 dwell cycles
        go(1'b1, 3'd6, 8'd3);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            pos = (k - 1) % 7;
            idx = (k - 1) / 7;
            esw = (k <= 42 && pos >= 4) ? (6'h01 << idx) : 6'h00;
            chk("scan.sw_en",  k, 32'(sw_en),  32'(esw));
            chk("scan.sample", k, 32'(sample), 32'(k <= 42 && pos == 6));
            chk("scan.busy",   k, 32'(busy),   32'(k <= 42));
            chk("scan.done",   k, 32'(done),   32'(k == 43));
            chk("scan.onehot", k, 32'($countones(sw_en) <= 1), 32'd1);
            adv();
        end

        // Abort during channel 1 ON
        go(1'b1, 3'd0, 8'd10);
        for (int k = 1; k <= 30; k++) begin
            stop = (k == 20);
            @(negedge clk);
            pos = (k - 1) % 14;
            idx = (k - 1) / 14;
            if (k <= 20)
                chk_all("abort", k, (pos >= 4) ? (6'h01 << idx) : 6'h00, 1, pos == 13, 0, 0, 3'(idx));
            else
                chk_all("abort", k, 6'h00, 0, 0, k == 21, 0, 3'd1);
            adv();
        end
        stop = 1'b0;

        // Reset in cycle 6 of a single sequence
        go(1'b0, 3'd2, 8'd3);
        for (int k = 1; k <= 10; k++) begin
            rst = (k == 6);
            @(negedge clk);
            if (k <= 4)      chk_all("rstmid", k, 6'h00, 1, 0, 0, 0, 3'd2);
            else if (k <= 6) chk_all("rstmid", k, 6'h04, 1, 0, 0, 0, 3'd2);
            else             chk_all("rstmid", k, 6'h00, 0, 0, 0, 0, 3'd0);
            adv();
        end
        rst = 1'b0;

        // Maximum dwell 255 on channel 0
        go(1'b0, 3'd0, 8'd255);
        for (int k = 1; k <= 261; k++) begin
            @(negedge clk);
            chk("maxdw.sw_en",  k, 32'(sw_en),  32'((k >= 5 && k <= 259) ? 6'h01 : 6'h00));
            chk("maxdw.sample", k, 32'(sample), 32'(k == 259));
            chk("maxdw.busy",   k, 32'(busy),   32'(k <= 259));
            chk("maxdw.done",   k, 32'(done),   32'(k == 260));
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ua_switch_sequencer.md
# ua_switch_sequencer

Sequences the analog pin switch matrix for the ua[5:0] analog pads of the tile. The block drives one-hot switch enables with break-before-make dead time and a programmable dwell per channel. It scans all channels or connects a single selected channel, and strobes a sample pulse at the end of each dwell for the downstream comparator or ADC capture logic. It sits between the digital control inputs (ui_in) and the analog switch drivers.

## Interface

Parameters:
- NCH, 6: number of analog channels (ua[NCH-1:0]); 2..8.
- DW, 8: dwell counter width.
- DEAD, 4: break-before-make cycles, all switches open; at least 1.

Ports:
- clk  in  1  clock; the tile clock.
- rst  in  1  reset; synchronous, active-high. Driven from ~rst_n at the tile top.
- start  in  1  single-cycle request to begin a sequence.
- stop  in  1  abort the current sequence.
- auto  in  1  1 = scan channels 0..NCH-1; 0 = single channel ch_sel.
- ch_sel  in  3  channel for single mode.
- dwell  in  DW  connected cycles per channel; 0 is treated as 1.
- sw_en  out  NCH  switch enables; one-hot or all-zero.
- ch_cur  out  3  current channel index.
- busy  out  1  sequence in progress.
- sample  out  1  one-cycle strobe on the last connected cycle of each channel.
- done  out  1  one-cycle pulse when a sequence ends (normal end or abort).
- err  out  1  one-cycle pulse when a start is rejected.

## Operation

Reset values: all outputs are 0 on the cycle after rst is sampled high. The FSM goes to IDLE, the counters go to 0, and ch_cur goes to 0. Reset mid-sequence opens all switches on the next cycle, with no done pulse.

FSM states are IDLE, BREAK and ON.

- **IDLE:** sw_en=0 and busy=0.
  - On start with stop=0, the block latches auto, ch_sel and dwell (treated as max(dwell,1)).
  - The first channel is 0 when auto=1, otherwise ch_sel. The block then goes to BREAK.
- **Rejected start:** if auto=0 and ch_sel≥NCH, the block stays in IDLE and pulses err. busy and done stay 0.
- **BREAK:** sw_en=0 and busy=1. It counts DEAD cycles, then goes to ON.
- **ON:** sw_en[ch_cur]=1, all other bits 0, busy=1. It counts the latched dwell cycles.
  - sample=1 on the final ON cycle.
  - After that cycle: if auto=1 and ch_cur<NCH-1, ch_cur increments and the block goes to BREAK.
  - Otherwise it goes to IDLE and pulses done.
- **No overlap:** two sw_en bits are never high in the same cycle. Every channel change passes through at least DEAD all-zero cycles.

Input rules:
- stop in BREAK or ON: the next cycle is IDLE, with sw_en=0, busy=0 and done=1. No sample is issued for the aborted channel.
- stop in IDLE: ignored. stop and start in the same IDLE cycle: stop wins, no sequence starts and no err is raised.
- start while busy: ignored.
- Input changes mid-sequence (dwell, auto, ch_sel): no effect, because these values are latched at start.
- ch_cur holds its last value in IDLE until the next accepted start.

## Timing

Cycle numbering: the start that is sampled at edge 0 makes cycle 1 the first registered-output cycle.

- **Single mode:**
  - Cycles 1..DEAD: BREAK.
  - Cycles DEAD+1..DEAD+dwell: ON. sample is high in cycle DEAD+dwell.
  - Cycle DEAD+dwell+1: done=1, busy=0.
- **Auto mode:**
  - Each channel occupies DEAD+dwell cycles.
  - busy is high for NCH·(DEAD+dwell) cycles.
  - done is high in cycle NCH·(DEAD+dwell)+1.
- **Back-to-back:** a new start is accepted in the same cycle that done is high, since the FSM is in IDLE.
- **Registers:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Counter width:** the dwell counter is DW bits wide with no wrap. dwell = 2^DW−1 must be supported exactly.

## Test plan

Defaults: DEAD=4, NCH=6.

- **Single channel:** auto=0, ch_sel=2, dwell=3, start at edge 0.
  - sw_en=0 in cycles 1–4, sw_en=6'b000100 in cycles 5–7.
  - sample in cycle 7, done in cycle 8, busy in cycles 1–7.
- **Auto scan:** auto=1, dwell=3.
  - sw_en walks 000001 through 100000. Each channel is preceded by 4 all-zero cycles.
  - There are 6 sample pulses at cycles 7, 14, …, 42, and done at cycle 43.
  - At no cycle is popcount(sw_en) greater than 1.
- **Abort:** auto=1, dwell=10, stop asserted at cycle 20 (during channel 1, ON).
  - sw_en=0, busy=0 and done=1 at cycle 21.
  - No sample at cycle 28 or later.
- **Edge inputs:**
  - dwell=0 behaves as dwell=1: one ON cycle, which carries sample.
  - ch_sel=7 with auto=0 gives err=1 for one cycle, with busy and sw_en staying 0.
- **Simultaneous and mid-operation events:**
  - start+stop together in IDLE: nothing happens.
  - start while busy: ignored, and timing is unchanged.
  - rst at cycle 6 of a single sequence: all outputs are 0 at cycle 7, and there is no done.
